dense_seq: RTL and testbench
============================

# dense_seq

Time-multiplexed fixed-point fully-connected layer: the next generation of `dense` for the classifier tail.
- Streams an `IN_NUM`-element input vector into an internal buffer.
- Computes `OUT_NUM` dot products one output at a time with a single multiply-accumulator, fetching weights from an external synchronous-read memory.
- Emits each biased, rounded and saturated result on a valid/ready stream.
- Replaces the fully parallel float datapath with a parametrised sequential engine sized for synthesis.

## Interface
- `IN_NUM`, 64: input vector length (≥2).
- `OUT_NUM`, 16: number of output neurons (≥1).
- `DATA_WIDTH`, 16: signed two's-complement width of data, weights, bias and results.
- `FRAC`, 8: fractional bits of the shared Q format (1 ≤ FRAC < DATA_WIDTH).
- `ACC_WIDTH`, 40: signed accumulator width (≥ 2*DATA_WIDTH + clog2(IN_NUM) + 1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a new vector; sampled only in IDLE.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse after the last output handshake.
- `in_valid_i` in 1: input sample valid.
- `in_data_i` in DATA_WIDTH: input sample, element 0 first.
- `in_ready_o` out 1: high only in LOAD.
- `w_en_o` out 1: weight read enable.
- `w_addr_o` out clog2(IN_NUM*OUT_NUM): weight address `o*IN_NUM + i`.
- `w_data_i` in DATA_WIDTH: weight; valid exactly one cycle after `w_en_o`.
- `bias_i` in OUT_NUM*DATA_WIDTH: flat bias vector, element o at `[o*DATA_WIDTH +: DATA_WIDTH]`; held stable while `busy_o`.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: downstream accepts.
- `out_data_o` out DATA_WIDTH: result.
- `out_idx_o` out clog2(OUT_NUM): neuron index of `out_data_o`.
- `out_last_o` out 1: high with the result for index OUT_NUM-1.

## Operation
States:
- **IDLE**: `start_i` goes to LOAD.
- **LOAD**: each `in_valid_i & in_ready_o` stores the sample at `buf[i]` and increments i. After the IN_NUM-th sample, go to MAC with o=0.
- **MAC**: c counts 0..IN_NUM.
  - c=0: `acc <= sext(bias[o]) <<< FRAC`.
  - For c<IN_NUM: `w_en_o=1`, `w_addr_o=o*IN_NUM+c`.
  - For c≥1: `acc <= acc + buf[c-1]*w_data_i`, using a full 2*DATA_WIDTH signed product, sign-extended.
  - After c=IN_NUM, go to OUT.
- **OUT**: the result register holds `sat(((acc + 2^(FRAC-1)) >>> FRAC))`, i.e. round half up, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. `out_valid_o=1`.
  - On handshake with o<OUT_NUM-1: o++, go to MAC.
  - On handshake with o=OUT_NUM-1: go to DONE.
- **DONE**: `done_o=1` for one cycle, then IDLE.

Rules:
- `start_i` is ignored outside IDLE.
- `in_valid_i` is ignored outside LOAD.
- The accumulator does not overflow for parameters meeting the ACC_WIDTH rule; only the final narrowing saturates.

## Timing
- Reset values:
  - state=IDLE; counters=0.
  - All outputs 0: `busy_o`, `done_o`, `in_ready_o`, `w_en_o`, `w_addr_o`, `out_valid_o`, `out_data_o`, `out_idx_o`, `out_last_o`.
- `rst` mid-operation (any state) forces reset values on the next edge and discards the partial vector. A `start_i` in the same cycle as `rst` is ignored.
- `in_ready_o` rises the cycle after `start_i` is accepted.
- MAC occupies exactly IN_NUM+1 cycles per neuron. `out_valid_o` rises the cycle after MAC c=IN_NUM.
- Throughput without backpressure:
  - IN_NUM+2 cycles per neuron.
  - Full vector: 1 (start) + IN_NUM (load, if `in_valid_i` is continuous) + OUT_NUM*(IN_NUM+2) cycles, then the `done_o` cycle.
- Backpressure: while `out_valid_o & !out_ready_i`, the outputs `out_data_o`, `out_idx_o` and `out_last_o` hold, and no weight reads are issued.
- `out_valid_o` never drops without a handshake, except on `rst`.

## Configuration
- `DENSE_SEQ_RELU_EN` defined: after rounding and saturation, negative results are replaced by 0.
- `DENSE_SEQ_RELU_EN` undefined: signed results pass unchanged.
- The macro does not affect timing.

## Test plan
Configuration for all scenarios: IN_NUM=4, OUT_NUM=2, DATA_WIDTH=16, FRAC=8.

- **Basic**:
  - Stimulus: x=256 ×4, weights=128, bias={64,-64}.
  - Required: `out_data_o`=576 (idx 0), then 448 (idx 1, `out_last_o`=1), then a `done_o` pulse.
  - Required latency: exactly 6 cycles per neuron with `out_ready_i`=1.
- **Rounding**:
  - Stimulus: x={1,0,0,0}, w0=128, all other weights and biases 0.
  - Required: result 1 (128+128>>8).
  - Same stimulus with w0=127: result 0.
- **Saturation / ReLU**:
  - Stimulus: x=32767 ×4, weights 32767, bias 0. Required: 32767.
  - Stimulus: weights -32768. Required: -32768 without the macro, 0 with `DENSE_SEQ_RELU_EN`.
- **Backpressure**:
  - Stimulus: hold `out_ready_i`=0 for 5 cycles at idx 0.
  - Required: outputs stable, `w_en_o`=0 throughout; idx 1 result unchanged, delayed by 5 cycles.
- **Gapped input**:
  - Stimulus: `in_valid_i` toggled 1/0 during LOAD, plus `start_i` pulsed during MAC.
  - Required: same results as Basic; the extra start is ignored.
- **Reset mid-MAC**:
  - Stimulus: assert `rst` at MAC c=2.
  - Required: all outputs 0 next cycle; a following full run reproduces the Basic results.

Source files
------------

// File: rtl/dense_seq.sv
// dense_seq: sequential fixed-point fully-connected layer, one MAC, external synchronous weight memory.
// Latency: 1 start + IN_NUM load + OUT_NUM*(IN_NUM+2) cycles, then a done_o cycle; DENSE_SEQ_RELU_EN clamps negatives to 0.
// Backpressure: a stalled result holds data/idx/last and suspends weight reads until out_ready_i.
module dense_seq #(
  parameter  int IN_NUM     = 64,
  parameter  int OUT_NUM    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAC       = 8,
  parameter  int ACC_WIDTH  = 40,
  localparam int AW = (IN_NUM * OUT_NUM > 1) ? $clog2(IN_NUM * OUT_NUM) : 1,
  localparam int OW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          in_valid_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          in_ready_o,
  output logic                          w_en_o,
  output logic [AW-1:0]                 w_addr_o,
  input  logic [DATA_WIDTH-1:0]         w_data_i,
  input  logic [OUT_NUM*DATA_WIDTH-1:0] bias_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [OW-1:0]                 out_idx_o,
  output logic                          out_last_o
);

  localparam int LW = $clog2(IN_NUM);
  localparam int IW = $clog2(IN_NUM + 1);

  localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(1) << (FRAC - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX  =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN  =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0]                 i_q;
  logic [IW-1:0]                 c_q;
  logic [OW-1:0]                 o_q;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  res_q, res_d;
  logic signed [DATA_WIDTH-1:0]  in_buf [IN_NUM];

  logic                          last_in, mac_last, o_last;
  logic [LW-1:0]                 pidx;
  logic signed [DATA_WIDTH-1:0]  bias_sel;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]     rnd_sum, rnd_sh;

  assign last_in  = (i_q == LW'(IN_NUM - 1));
  assign mac_last = (c_q == IW'(IN_NUM));
  assign o_last   = (o_q == OW'(OUT_NUM - 1));
  assign pidx     = LW'(c_q - IW'(1));
  assign bias_sel = bias_i[int'(o_q)*DATA_WIDTH +: DATA_WIDTH];

  assign out_data_o = res_q;
  assign out_idx_o  = o_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    in_ready_o  = (state_q == S_LOAD);
    w_en_o      = 1'b0;
    w_addr_o    = '0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_LOAD;
      S_LOAD: if (in_valid_i && last_in) state_d = S_MAC;
      S_MAC: begin
        if (c_q < IW'(IN_NUM)) begin
          w_en_o   = 1'b1;
          w_addr_o = AW'(o_q) * AW'(IN_NUM) + AW'(c_q);
        end
        if (mac_last) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        out_last_o  = o_last;
        if (out_ready_i) state_d = o_last ? S_DONE : S_MAC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // c=0 seeds the bias; later cycles consume the weight fetched one cycle earlier.
  always_comb begin
    prod  = in_buf[pidx] * $signed(w_data_i);
    acc_d = acc_q;
    if (c_q == '0)
      acc_d = {{(ACC_WIDTH-DATA_WIDTH){bias_sel[DATA_WIDTH-1]}}, bias_sel} <<< FRAC;
    else
      acc_d = acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    rnd_sum = {acc_d[ACC_WIDTH-1], acc_d} + RND_HALF;
    rnd_sh  = rnd_sum >>> FRAC;
    if (rnd_sh > SAT_MAX)      res_d = SAT_MAX[DATA_WIDTH-1:0];
    else if (rnd_sh < SAT_MIN) res_d = SAT_MIN[DATA_WIDTH-1:0];
    else                       res_d = rnd_sh[DATA_WIDTH-1:0];
`ifdef DENSE_SEQ_RELU_EN
    if (res_d[DATA_WIDTH-1]) res_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q   <= '0;
      c_q   <= '0;
      o_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          i_q <= '0;
          c_q <= '0;
          o_q <= '0;
        end
        S_LOAD: if (in_valid_i) i_q <= last_in ? '0 : i_q + LW'(1);
        S_MAC: begin
          acc_q <= acc_d;
          c_q   <= mac_last ? '0 : c_q + IW'(1);
          if (mac_last) res_q <= res_d;
        end
        S_OUT:   if (out_ready_i && !o_last) o_q <= o_q + OW'(1);
        S_DONE:  o_q <= '0;
        default: ;
      endcase
    end
  end

  // Vector storage needs no reset: it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_LOAD && in_valid_i) in_buf[i_q] <= $signed(in_data_i);
  end

endmodule

// File: tb/tb_dense_seq.sv
// Scoreboard bench for dense_seq at IN_NUM=4, OUT_NUM=2, DATA_WIDTH=16, FRAC=8.
module tb_dense_seq;
  localparam int IN_NUM = 4, OUT_NUM = 2, DW = 16, FRAC = 8, ACCW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_ready_o;
  logic          w_en_o;
  logic [2:0]    w_addr_o;
  logic [DW-1:0] w_data_i = '0;
  logic [31:0]   bias_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic [0:0]    out_idx_o;
  logic          out_last_o;

  dense_seq #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .DATA_WIDTH(DW), .FRAC(FRAC), .ACC_WIDTH(ACCW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .w_en_o(w_en_o), .w_addr_o(w_addr_o), .w_data_i(w_data_i), .bias_i(bias_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_idx_o(out_idx_o), .out_last_o(out_last_o)
  );

  always #5 clk = ~clk;

  int x_v [IN_NUM];
  int w_v [IN_NUM*OUT_NUM];
  int b_v [OUT_NUM];

  always @(posedge clk) if (w_en_o) w_data_i <= 16'(w_v[w_addr_o]);

  typedef struct { longint data; int idx; bit last; } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, exp_lat0 = 0, last_hs = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [0:0]    pi = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(act), $signed(exp), $time);
    end
  endtask

  function automatic longint model(int o);
    longint acc, r;
    acc = longint'(b_v[o]) * 256;
    for (int i = 0; i < IN_NUM; i++) acc += longint'(x_v[i]) * longint'(w_v[o*IN_NUM+i]);
    r = (acc + 128) >>> FRAC;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef DENSE_SEQ_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_data", out_data_o, pd);
        check("hold_idx", out_idx_o, pi);
        check("hold_last", out_last_o, pl);
      end
      if (out_valid_o && !out_ready_i) check("stall_w_en", w_en_o, 0);
      if (out_valid_o && out_ready_i) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", $signed(out_data_o), e.data);
          check("out_idx", out_idx_o, e.idx);
          check("out_last", out_last_o, e.last);
          if (out_idx_o == 0) check("lat_first", cyc - t0, exp_lat0);
          else                check("lat_neuron", cyc - last_hs, IN_NUM + 2);
        end
        last_hs <= cyc;
      end
      if (done_o) check("done_after_last", cyc - last_hs, 1);
    end
    pv <= out_valid_o && !rst;
    pr <= out_ready_i;
    pd <= out_data_o;
    pi <= out_idx_o;
    pl <= out_last_o;
  end

  task automatic load_vec(input int gap);
    for (int k = 0; k < IN_NUM; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 16'(x_v[k]);
      @(posedge clk); #1;
      if (gap != 0) begin
        in_valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid_i = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic run_vec(input int gap, input int stall, input bit extra_start);
    int n;
    for (int o = 0; o < OUT_NUM; o++) begin
      exp_t e;
      e.data = model(o);
      e.idx  = o;
      e.last = (o == OUT_NUM - 1);
      sb.push_back(e);
    end
    bias_i   = {16'(b_v[1]), 16'(b_v[0])};
    exp_lat0 = 2*IN_NUM + 1 + stall + ((gap != 0) ? IN_NUM - 1 : 0);
    start_i  = 1'b1;
    @(posedge clk); #1;
    t0      = cyc;
    start_i = 1'b0;
    check("in_ready_rise", in_ready_o, 1);
    check("busy_high", busy_o, 1);
    if (stall > 0) out_ready_i = 1'b0;
    load_vec(gap);
    if (extra_start) begin
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    if (stall > 0) begin
      n = 0;
      while (!out_valid_o && n < 100) begin @(posedge clk); #1; n++; end
      check("stall_reach_out", out_valid_o, 1);
      repeat (stall) @(posedge clk);
      #1 out_ready_i = 1'b1;
    end
    n = 0;
    while (!done_o && n < 200) begin @(posedge clk); #1; n++; end
    check("done_seen", done_o, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done_o, 0);
    check("busy_idle", busy_o, 0);
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic set_basic();
    for (int i = 0; i < IN_NUM; i++) x_v[i] = 256;
    for (int i = 0; i < IN_NUM*OUT_NUM; i++) w_v[i] = 128;
    b_v[0] = 64;
    b_v[1] = -64;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy_o, 0);
    check({pfx, "_done"}, done_o, 0);
    check({pfx, "_in_ready"}, in_ready_o, 0);
    check({pfx, "_w_en"}, w_en_o, 0);
    check({pfx, "_w_addr"}, w_addr_o, 0);
    check({pfx, "_out_valid"}, out_valid_o, 0);
    check({pfx, "_out_data"}, out_data_o, 0);
    check({pfx, "_out_idx"}, out_idx_o, 0);
    check({pfx, "_out_last"}, out_last_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic
    set_basic();
    check("model_basic0", model(0), 576);
    check("model_basic1", model(1), 448);
    run_vec(0, 0, 1'b0);

    // Rounding: half rounds up, just below half rounds down
    for (int i = 0; i < IN_NUM; i++) x_v[i] = (i == 0) ? 1 : 0;
    for (int i = 0; i < IN_NUM*OUT_NUM; i++) w_v[i] = 0;
    b_v[0] = 0; b_v[1] = 0;
    w_v[0] = 128;
    run_vec(0, 0, 1'b0);
    w_v[0] = 127;
    run_vec(0, 0, 1'b0);

    // Saturation, positive and negative (negative becomes 0 with ReLU)
    for (int i = 0; i < IN_NUM; i++) x_v[i] = 32767;
    for (int i = 0; i < IN_NUM*OUT_NUM; i++) w_v[i] = 32767;
    run_vec(0, 0, 1'b0);
    for (int i = 0; i < IN_NUM*OUT_NUM; i++) w_v[i] = -32768;
    run_vec(0, 0, 1'b0);

    // Backpressure at idx 0
    set_basic();
    run_vec(0, 5, 1'b0);

    // Gapped input plus a stray start during MAC
    run_vec(1, 0, 1'b1);

    // Reset at MAC c=2, with a simultaneous start that must be ignored
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    load_vec(0);
    repeat (2) @(posedge clk);
    #1 check("mac_c2_w_en", w_en_o, 1);
    check("mac_c2_w_addr", w_addr_o, 2);
    rst = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("rst_start_ignored", busy_o, 0);
    run_vec(0, 0, 1'b0);

    // Random vectors
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < IN_NUM; i++) x_v[i] = int'($urandom_range(8000)) - 4000;
      for (int i = 0; i < IN_NUM*OUT_NUM; i++) w_v[i] = int'($urandom_range(8000)) - 4000;
      for (int o = 0; o < OUT_NUM; o++) b_v[o] = int'($urandom_range(2000)) - 1000;
      run_vec(0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
